alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mc_mul.sv | 83 ++++++++
 rtl/alu_mc.sv | 168 ++++++++++++++++
 tb/tb_alu_mc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg -- definitions shared by the multi-cycle ALU (alu_mc) and its
// iterative multiplier (alu_mc_mul).
//   * opcode constants for the 4-bit control field
//   * bit positions of the {N,Z,C,V} flag vector
//   * FSM state enumeration used by alu_mc
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_mul.sv
// ---------------------------------------------------------------------------
// alu_mc_mul -- iterative shift-add multiplier, one multiplier bit per cycle.
// Only the low WIDTH bits of the product are kept.
//
// Timing: the start cycle consumes bit 0; bits 1..WIDTH-1 follow on the next
// WIDTH-1 cycles. done is a one-cycle pulse on the cycle after the last
// iteration, i.e. WIDTH cycles after start, with product valid alongside it.
//
// Ports:
//   clk      clock, rising edge
//   reset    synchronous active-high reset, aborts any multiply in flight
//   start    load a/b and begin (single-cycle pulse)
//   a, b     operands, sampled only when start=1
//   done     product valid this cycle
//   product  low WIDTH bits of a*b
// ---------------------------------------------------------------------------
module alu_mc_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q,   busy_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;   // a shifted left once per iteration
  logic [WIDTH-1:0] mplier_q, mplier_d;  // b shifted right; bit 0 is the current bit

  assign done    = busy_q && (cnt_q == CW'(WIDTH));
  assign product = acc_q;

  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CW'(1);
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
    end else if (busy_q && (cnt_q != CW'(WIDTH))) begin
      cnt_d    = cnt_q + CW'(1);
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end else if (busy_q) begin
      // Result handed over this cycle (done=1); go quiet.
      busy_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD SUB AND ORR MOV MVN EOR) finish one cycle after
// acceptance; MUL (optional) runs WIDTH cycles in BUSY on alu_mc_mul.
// Result and {N,Z,C,V} flags are registered and held until consumed.
//
// Build option: define ALU_MC_MUL_EN to enable MUL (1001). Without it, 1001
// is an unimplemented opcode and the multiplier is not instantiated.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   request valid          in_ready   accepting (IDLE only)
//   a, b       operands               control    opcode
//   out_valid  result valid (DONE)    out_ready  consumer accepts result
//   result     registered result      flags      registered {N,Z,C,V}
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  import alu_pkg::*;

  alu_state_e       state_q,     state_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic [3:0]       flags_q,     flags_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             mul_op;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [3:0]       alu_flags;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign accept = in_valid && in_ready_q;

`ifdef ALU_MC_MUL_EN
  assign mul_op = (control == OP_MUL);

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && mul_op),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  // BUSY is unreachable; the multiplier path folds away.
  assign mul_op      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle datapath. SUB is a + ~b + 1, so C=1 means no borrow.
  always_comb begin
    alu_sum = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (control)
      OP_ADD: begin
        alu_sum = {1'b0, a} + {1'b0, b};
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      OP_MOV:  alu_res = b;
      OP_MVN:  alu_res = ~b;
      default: alu_res = '0;  // unimplemented: result 0, only Z set
    endcase
    alu_flags = pack_flags(alu_res, alu_c, alu_v);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mul_op) begin
            state_d = BUSY;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flags_d  = alu_flags;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d  = DONE;
          result_d = mul_product;
          flags_d  = pack_flags(mul_product, 1'b0, 1'b0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- self-checking bench for alu_mc (WIDTH=32). Expected results are
// computed by an independent reference model, queued when a request is
// driven and popped when the DUT raises out_valid. MUL expectations follow
// ALU_MC_MUL_EN, so the bench works for both builds.
// ---------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    logic [W-1:0] result;
    logic [3:0]   flags;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: carries from a 64-bit sum, borrow from compare,
  // overflow from signed 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] wide;
    longint      s;
    logic        c, v;
    logic [W-1:0] r;
    c = 1'b0; v = 1'b0; r = '0;
    e.lat = 1;
    case (op)
      4'b0100: begin
        wide = {32'b0, x} + {32'b0, y};
        r = wide[W-1:0];
        c = (wide > 64'hFFFF_FFFF);
        s = longint'($signed(x)) + longint'($signed(y));
        v = (s != longint'($signed(r)));
      end
      4'b0010: begin
        r = x - y;
        c = (x >= y);
        s = longint'($signed(x)) - longint'($signed(y));
        v = (s != longint'($signed(r)));
      end
      4'b0000: r = x & y;
      4'b1100: r = x | y;
      4'b0001: r = x ^ y;
      4'b1101: r = y;
      4'b1111: r = ~y;
      4'b1001: begin
        if (MUL_EN) begin
          wide  = {32'b0, x} * {32'b0, y};
          r     = wide[W-1:0];
          e.lat = W + 1;
        end
      end
      default: r = '0;
    endcase
    e.result = r;
    e.flags  = {r[W-1], (r == '0), c, v};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, check latency and outputs against the scoreboard,
  // optionally stall the consumer, then complete the handshake.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int stall);
    exp_t e;
    int   lat;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; control = op; a = av; b = bv;
    sb_q.push_back(model(op, av, bv));
    tick();
    // Scramble inputs: they must not be sampled after acceptance.
    in_valid = 1'b0; control = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      check("busy_in_ready", in_ready, 0);
      tick();
      lat++;
    end
    e = sb_q.pop_front();
    check("latency", lat, e.lat);
    check("result", result, e.result);
    check("flags", flags, e.flags);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1; control = 4'b0100; a = $urandom; b = $urandom;
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, e.result);
      check("stall_flags", flags, e.flags);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  logic [3:0] ops [9] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101,
                          4'b1111, 4'b0001, 4'b1001, 4'b0111};

  initial begin
    bit seen;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; control = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    reset = 1'b0;
    tick();

    // Directed corner cases
    run_op(4'b0100, 32'h7FFF_FFFF, 32'h1, 0);           // signed overflow
    run_op(4'b0010, 32'd5, 32'd5, 0);                   // zero, no borrow
    run_op(4'b0010, 32'd0, 32'd1, 0);                   // borrow
    run_op(4'b0100, 32'hFFFF_FFFF, 32'h1, 0);           // carry + zero
    run_op(4'b0010, 32'h8000_0000, 32'h1, 0);           // SUB overflow
    run_op(4'b0000, 32'hF0F0_1234, 32'hFF00_FF00, 0);
    run_op(4'b1100, 32'hF0F0_1234, 32'h0F00_0001, 0);
    run_op(4'b0001, 32'hAAAA_5555, 32'hFFFF_0000, 0);
    run_op(4'b1101, 32'hDEAD_BEEF, 32'h8000_0000, 0);
    run_op(4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0);
    run_op(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, 0);   // unimplemented
    run_op(4'b1001, 32'h0001_0000, 32'h0001_0003, 0);   // MUL or unimplemented
    run_op(4'b0100, 32'd1, 32'd2, 5);                   // consumer stall

    // Random operations with random consumer stalls
    for (int i = 0; i < 24; i++)
      run_op(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom_range(0, 2));

    // Reset while holding a result in DONE: result is dropped
    in_valid = 1'b1; control = 4'b0100; a = 32'd1; b = 32'd2;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_done_out_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    check("rst_done_flags", flags, 0);
    check("rst_done_in_ready", in_ready, 1);
    seen = 1'b0;
    repeat (5) begin tick(); seen |= out_valid; end
    check("rst_done_no_late", seen, 0);

    if (MUL_EN) begin
      // Reset during cycle 10 of a multiply aborts it
      in_valid = 1'b1; control = 4'b1001; a = 32'h0001_0000; b = 32'h0001_0003;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      check("mul_mid_in_ready", in_ready, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_busy_out_valid", out_valid, 0);
      check("rst_busy_result", result, 0);
      check("rst_busy_flags", flags, 0);
      check("rst_busy_in_ready", in_ready, 1);
      seen = 1'b0;
      repeat (40) begin tick(); seen |= out_valid; end
      check("rst_busy_no_late", seen, 0);
    end

    // Recovery after reset
    run_op(4'b0100, 32'h0000_00FF, 32'h0000_0001, 0);
    run_op(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
